cacheline_arbiter: RTL and testbench

//  Shares the single cacheline adaptor between the icache and the dcache.

---
 rtl/cacheline_arbiter_if.sv | 37 +++
 rtl/cacheline_arbiter.sv | 128 ++++++++++++
 tb/tb_cacheline_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_arbiter_if.sv
// cacheline_arbiter_if
//   One line-granular memory port: a request (read or write, line address,
//   writeback line) travelling one way and the response (line data plus a
//   one-cycle completion strobe) travelling back.
//
//   Parameter
//     LINE     line width in bits
//   Signals
//     read     line-fill request
//     write    writeback request
//     address  32-bit line address
//     wdata    writeback line
//     rdata    returned line
//     resp     transaction complete
//   Modports
//     master   issues requests, receives rdata/resp
//     slave    receives requests, returns rdata/resp
interface cacheline_arbiter_if #(
  parameter int LINE = 256
);
  logic            read;
  logic            write;
  logic [31:0]     address;
  logic [LINE-1:0] wdata;
  logic [LINE-1:0] rdata;
  logic            resp;

  modport master (
    output read, write, address, wdata,
    input  rdata, resp
  );

  modport slave (
    input  read, write, address, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//   Shares the single cacheline adaptor between the icache and the dcache.
//   One whole line transaction (fill or writeback) is in flight at a time;
//   simultaneous requests are granted round-robin. The winning request is
//   captured into registers at grant so the adaptor sees stable inputs even
//   if the cache changes its signals mid-transaction.
//
//   Parameters
//     S_OFFSET  log2 bytes per line; LINE = (2**S_OFFSET)*8
//     CNT_W     width of the saturating grant counters
//   Ports
//     clk          clock, rising edge
//     reset_n      asynchronous active-low reset
//     i_bus        icache pmem port (slave; only read/address are used)
//     d_bus        dcache pmem port (slave)
//     c_bus        cacheline adaptor line port (master)
//     i_grant_cnt  icache grants since reset, saturating
//     d_grant_cnt  dcache grants since reset, saturating
module cacheline_arbiter #(
  parameter int S_OFFSET = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  cacheline_arbiter_if.slave  i_bus,
  cacheline_arbiter_if.slave  d_bus,
  cacheline_arbiter_if.master c_bus,
  output logic [CNT_W-1:0]    i_grant_cnt,
  output logic [CNT_W-1:0]    d_grant_cnt
);

  localparam int LINE = (2**S_OFFSET) * 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    GAP
  } state_t;

  state_t          state;
  logic            last_d;
  logic            read_q;
  logic            write_q;
  logic [31:0]     addr_q;
  logic [LINE-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;

  // The icache never writes back, so its write/wdata lines carry nothing.
  logic unused_icache_write;
  assign unused_icache_write = ^{i_bus.write, i_bus.wdata};

  assign i_req = i_bus.read;
  assign d_req = d_bus.read | d_bus.write;

  // On a tie the requester that did not win last time takes the grant;
  // last_d resets to 1 so the icache wins the first tie.
  assign grant_i = i_req & (~d_req | last_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state   <= BUSY_I;
            last_d  <= 1'b0;
            read_q  <= 1'b1;
            write_q <= 1'b0;
            addr_q  <= i_bus.address;
            wdata_q <= '0;
            if (i_grant_cnt != {CNT_W{1'b1}})
              i_grant_cnt <= i_grant_cnt + 1'b1;
          end else if (d_req) begin
            // A writeback takes precedence over a fill raised alongside it.
            state   <= BUSY_D;
            last_d  <= 1'b1;
            read_q  <= ~d_bus.write;
            write_q <= d_bus.write;
            addr_q  <= d_bus.address;
            wdata_q <= d_bus.wdata;
            if (d_grant_cnt != {CNT_W{1'b1}})
              d_grant_cnt <= d_grant_cnt + 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (c_bus.resp) begin
            state   <= GAP;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
          end
        end
        GAP: begin
          // One dead cycle so the served cache can drop or refresh its request.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign c_bus.read    = read_q;
  assign c_bus.write   = write_q;
  assign c_bus.address = addr_q;
  assign c_bus.wdata   = wdata_q;

  // Returned data and completion go only to the requester that holds the grant.
  assign i_bus.rdata = (state == BUSY_I) ? c_bus.rdata : '0;
  assign i_bus.resp  = (state == BUSY_I) & c_bus.resp;
  assign d_bus.rdata = (state == BUSY_D) ? c_bus.rdata : '0;
  assign d_bus.resp  = (state == BUSY_D) & c_bus.resp;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter
//   Self-checking bench for cacheline_arbiter: a table of per-cycle vectors,
//   hand-written multi-cycle sequences, randomized traffic against a
//   transaction-level reference model, and a second instance with CNT_W=2
//   for counter saturation.
module tb_cacheline_arbiter;

  localparam int LINE = 256;

  logic clk = 1'b0;
  logic reset_n;

  int vectors     = 0;
  int miscompares = 0;

  cacheline_arbiter_if #(.LINE(LINE)) i_bus ();
  cacheline_arbiter_if #(.LINE(LINE)) d_bus ();
  cacheline_arbiter_if #(.LINE(LINE)) c_bus ();
  cacheline_arbiter_if #(.LINE(LINE)) s_i ();
  cacheline_arbiter_if #(.LINE(LINE)) s_d ();
  cacheline_arbiter_if #(.LINE(LINE)) s_c ();

  logic [15:0] i_cnt;
  logic [15:0] d_cnt;
  logic [1:0]  s_icnt;
  logic [1:0]  s_dcnt;

  cacheline_arbiter #(.S_OFFSET(5), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_bus       (i_bus),
    .d_bus       (d_bus),
    .c_bus       (c_bus),
    .i_grant_cnt (i_cnt),
    .d_grant_cnt (d_cnt)
  );

  cacheline_arbiter #(.S_OFFSET(5), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_bus       (s_i),
    .d_bus       (s_d),
    .c_bus       (s_c),
    .i_grant_cnt (s_icnt),
    .d_grant_cnt (s_dcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwp;
    logic        rs;
    logic [31:0] rp;
    logic        e_read;
    logic        e_write;
    logic        chk_bus;
    logic [31:0] e_addr;
    logic [31:0] e_wp;
    logic        e_iresp;
    logic [31:0] e_irp;
    logic        e_dresp;
    logic [31:0] e_drp;
    logic [15:0] e_icnt;
    logic [15:0] e_dcnt;
  } vec_t;

  function automatic logic [LINE-1:0] rep(input logic [31:0] p);
    return {8{p}};
  endfunction

  task automatic checkOutput(input string name, input logic [LINE-1:0] act,
                             input logic [LINE-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    i_bus.read = 0; i_bus.write = 0; i_bus.address = 0; i_bus.wdata = '0;
    d_bus.read = 0; d_bus.write = 0; d_bus.address = 0; d_bus.wdata = '0;
    c_bus.rdata = '0; c_bus.resp = 0;
    s_i.read = 0; s_i.write = 0; s_i.address = 0; s_i.wdata = '0;
    s_d.read = 0; s_d.write = 0; s_d.address = 0; s_d.wdata = '0;
    s_c.rdata = '0; s_c.resp = 0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic resetDut();
    @(negedge clk);
    reset_n = 0;
    clearInputs();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic applyStimulus(input vec_t v);
    i_bus.read    = v.ir;
    i_bus.address = v.ia;
    d_bus.read    = v.dr;
    d_bus.write   = v.dw;
    d_bus.address = v.da;
    d_bus.wdata   = rep(v.dwp);
    c_bus.resp    = v.rs;
    c_bus.rdata   = rep(v.rp);
  endtask

  // Waits (bounded) for a grant on the main instance; who = 1 icache, 2 dcache.
  task automatic waitGrant(output int who);
    who = 0;
    for (int k = 0; k < 8 && who == 0; k++) begin
      @(negedge clk);
      #1;
      if (c_bus.read || c_bus.write)
        who = (c_bus.address == 32'h100) ? 1 : 2;
    end
    if (who == 0) checkOutput("grant_timeout", 0, 1);
  endtask

  vec_t vecs[$];

  initial begin
    int who;
    int owner;
    bit in_gap;
    bit last_d;
    logic tr, tw;
    logic [31:0] ta;
    logic [LINE-1:0] twd;
    int ic, dc;
    int grants;

    reset_n = 1;
    clearInputs();

    //        rst ir  ia   dr dw da   dwp           rs rp            er ew cb ea   ewp           eir eirp         edr edrp         eic edc
    vecs.push_back('{1, 1, 'h100, 0, 1, 'h200, 'hDEADBEEF, 0, 'h0,        0, 0, 1, 'h0,  'h0,        0, 'h0,        0, 'h0,        0, 0});
    vecs.push_back('{0, 1, 'h100, 0, 1, 'h200, 'hDEADBEEF, 0, 'h11111111, 1, 0, 1, 'h100,'h0,        0, 'h11111111, 0, 'h0,        1, 0});
    vecs.push_back('{0, 1, 'h100, 0, 1, 'h200, 'hDEADBEEF, 1, 'h22222222, 1, 0, 1, 'h100,'h0,        1, 'h22222222, 0, 'h0,        1, 0});
    vecs.push_back('{0, 0, 'h0,   0, 1, 'h200, 'hDEADBEEF, 0, 'h33333333, 0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 0});
    vecs.push_back('{0, 0, 'h0,   0, 1, 'h200, 'hDEADBEEF, 0, 'h33333333, 0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 0});
    vecs.push_back('{0, 0, 'h0,   0, 1, 'h200, 'hDEADBEEF, 0, 'h44444444, 0, 1, 1, 'h200,'hDEADBEEF, 0, 'h0,        0, 'h44444444, 1, 1});
    vecs.push_back('{0, 0, 'h0,   0, 1, 'h200, 'hDEADBEEF, 1, 'h55555555, 0, 1, 1, 'h200,'hDEADBEEF, 0, 'h0,        1, 'h55555555, 1, 1});
    vecs.push_back('{0, 0, 'h0,   0, 0, 'h0,   'h0,        0, 'h66666666, 0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 1});
    vecs.push_back('{1, 1, 'h40,  0, 0, 'h0,   'h0,        0, 'h0,        0, 0, 1, 'h0,  'h0,        0, 'h0,        0, 'h0,        0, 0});
    vecs.push_back('{0, 1, 'h40,  0, 0, 'h0,   'h0,        0, 'h0,        1, 0, 1, 'h40, 'h0,        0, 'h0,        0, 'h0,        1, 0});
    vecs.push_back('{0, 1, 'h40,  0, 0, 'h0,   'h0,        1, 'hA5A5A5A5, 1, 0, 1, 'h40, 'h0,        1, 'hA5A5A5A5, 0, 'h0,        1, 0});
    vecs.push_back('{0, 0, 'h0,   0, 0, 'h0,   'h0,        0, 'h0,        0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 0});
    vecs.push_back('{0, 0, 'h0,   1, 1, 'h80,  'hCAFEF00D, 1, 'h77777777, 0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 0});
    vecs.push_back('{0, 0, 'h0,   1, 1, 'h80,  'hCAFEF00D, 0, 'h0,        0, 1, 1, 'h80, 'hCAFEF00D, 0, 'h0,        0, 'h0,        1, 1});
    vecs.push_back('{0, 0, 'h0,   1, 1, 'h80,  'hCAFEF00D, 1, 'h12345678, 0, 1, 1, 'h80, 'hCAFEF00D, 0, 'h0,        1, 'h12345678, 1, 1});
    vecs.push_back('{0, 0, 'h0,   0, 0, 'h0,   'h0,        1, 'h9,        0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 1});
    vecs.push_back('{0, 0, 'h0,   0, 0, 'h0,   'h0,        1, 'h9,        0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 1});
    vecs.push_back('{0, 0, 'h0,   1, 0, 'h90,  'h0,        0, 'h0,        0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 1});
    vecs.push_back('{0, 0, 'h0,   1, 0, 'h90,  'h0,        0, 'h0,        1, 0, 1, 'h90, 'h0,        0, 'h0,        0, 'h0,        1, 2});
    vecs.push_back('{0, 0, 'h0,   1, 0, 'h90,  'h0,        1, 'hABCD0123, 1, 0, 1, 'h90, 'h0,        0, 'h0,        1, 'hABCD0123, 1, 2});
    vecs.push_back('{0, 0, 'h0,   0, 0, 'h0,   'h0,        0, 'h0,        0, 0, 0, 'h0,  'h0,        0, 'h0,        0, 'h0,        1, 2});

    $display("[TB] table vectors");
    foreach (vecs[n]) begin
      if (vecs[n].rst) resetDut();
      else @(negedge clk);
      applyStimulus(vecs[n]);
      #1;
      checkOutput($sformatf("v%0d_read_c", n),  c_bus.read,  vecs[n].e_read);
      checkOutput($sformatf("v%0d_write_c", n), c_bus.write, vecs[n].e_write);
      if (vecs[n].chk_bus) begin
        checkOutput($sformatf("v%0d_addr_c", n),  c_bus.address, vecs[n].e_addr);
        checkOutput($sformatf("v%0d_wdata_c", n), c_bus.wdata,   rep(vecs[n].e_wp));
      end
      checkOutput($sformatf("v%0d_i_resp", n),  i_bus.resp,  vecs[n].e_iresp);
      checkOutput($sformatf("v%0d_i_rdata", n), i_bus.rdata, rep(vecs[n].e_irp));
      checkOutput($sformatf("v%0d_d_resp", n),  d_bus.resp,  vecs[n].e_dresp);
      checkOutput($sformatf("v%0d_d_rdata", n), d_bus.rdata, rep(vecs[n].e_drp));
      checkOutput($sformatf("v%0d_i_cnt", n),   i_cnt,       vecs[n].e_icnt);
      checkOutput($sformatf("v%0d_d_cnt", n),   d_cnt,       vecs[n].e_dcnt);
    end

    $display("[TB] alternation under continuous dual requests");
    resetDut();
    i_bus.read = 1; i_bus.address = 32'h100;
    d_bus.read = 1; d_bus.address = 32'h200;
    for (int t = 0; t < 6; t++) begin
      waitGrant(who);
      checkOutput($sformatf("alt_order%0d", t), who, (t % 2 == 0) ? 1 : 2);
      c_bus.resp = 1;
      #1;
      checkOutput($sformatf("alt_iresp%0d", t), i_bus.resp, (who == 1) ? 1 : 0);
      checkOutput($sformatf("alt_dresp%0d", t), d_bus.resp, (who == 2) ? 1 : 0);
      @(negedge clk);
      c_bus.resp = 0;
    end
    checkOutput("alt_i_cnt", i_cnt, 3);
    checkOutput("alt_d_cnt", d_cnt, 3);

    $display("[TB] request changes ignored while busy");
    resetDut();
    d_bus.write = 1; d_bus.address = 32'h200; d_bus.wdata = rep(32'h0BADF00D);
    waitGrant(who);
    checkOutput("hold_grant", who, 2);
    @(negedge clk);
    d_bus.address = 32'h300;
    i_bus.read = 1; i_bus.address = 32'h100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("hold_addr%0d", k),  c_bus.address, 32'h200);
      checkOutput($sformatf("hold_write%0d", k), c_bus.write, 1);
      checkOutput($sformatf("hold_iresp%0d", k), i_bus.resp, 0);
      @(negedge clk);
    end
    c_bus.resp = 1;
    #1;
    checkOutput("hold_dresp", d_bus.resp, 1);
    checkOutput("hold_iresp_end", i_bus.resp, 0);
    checkOutput("hold_addr_end", c_bus.address, 32'h200);
    @(negedge clk);
    clearInputs();

    $display("[TB] reset in the middle of a transaction");
    resetDut();
    i_bus.read = 1; i_bus.address = 32'h40;
    @(negedge clk);
    #1;
    checkOutput("mid_busy_read", c_bus.read, 1);
    #2;
    reset_n = 0;
    #1;
    checkOutput("mid_rst_read",  c_bus.read, 0);
    checkOutput("mid_rst_addr",  c_bus.address, 0);
    checkOutput("mid_rst_i_cnt", i_cnt, 0);
    checkOutput("mid_rst_iresp", i_bus.resp, 0);
    @(negedge clk);
    clearInputs();
    d_bus.read = 1; d_bus.address = 32'h500;
    reset_n = 1;
    @(negedge clk);
    #1;
    checkOutput("post_rst_read", c_bus.read, 1);
    checkOutput("post_rst_addr", c_bus.address, 32'h500);
    checkOutput("post_rst_d_cnt", d_cnt, 1);

    $display("[TB] randomized traffic against reference model");
    resetDut();
    owner = 0; in_gap = 0; last_d = 1; ic = 0; dc = 0;
    tr = 0; tw = 0; ta = 0; twd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      i_bus.read    = ($urandom_range(0, 9) < 4);
      i_bus.address = $urandom();
      d_bus.read    = ($urandom_range(0, 9) < 3);
      d_bus.write   = ($urandom_range(0, 9) < 3);
      d_bus.address = $urandom();
      d_bus.wdata   = rep($urandom());
      c_bus.resp    = ($urandom_range(0, 2) == 0);
      c_bus.rdata   = rep($urandom());
      #1;
      checkOutput("rnd_read_c",  c_bus.read,  (owner != 0) ? tr : 1'b0);
      checkOutput("rnd_write_c", c_bus.write, (owner != 0) ? tw : 1'b0);
      if (owner != 0) begin
        checkOutput("rnd_addr_c",  c_bus.address, ta);
        checkOutput("rnd_wdata_c", c_bus.wdata, twd);
      end
      checkOutput("rnd_i_resp",  i_bus.resp,  (owner == 1) && c_bus.resp);
      checkOutput("rnd_i_rdata", i_bus.rdata, (owner == 1) ? c_bus.rdata : '0);
      checkOutput("rnd_d_resp",  d_bus.resp,  (owner == 2) && c_bus.resp);
      checkOutput("rnd_d_rdata", d_bus.rdata, (owner == 2) ? c_bus.rdata : '0);
      checkOutput("rnd_i_cnt", i_cnt, (ic > 65535) ? 65535 : ic);
      checkOutput("rnd_d_cnt", d_cnt, (dc > 65535) ? 65535 : dc);
      // Advance the model across the coming rising edge.
      if (owner != 0) begin
        if (c_bus.resp) begin
          owner  = 0;
          in_gap = 1;
        end
      end else if (in_gap) begin
        in_gap = 0;
      end else if (i_bus.read || d_bus.read || d_bus.write) begin
        if (i_bus.read && (!(d_bus.read || d_bus.write) || last_d)) begin
          owner = 1; last_d = 0; ic++;
          tr = 1; tw = 0; ta = i_bus.address; twd = '0;
        end else begin
          owner = 2; last_d = 1; dc++;
          tw = d_bus.write; tr = !d_bus.write;
          ta = d_bus.address; twd = d_bus.wdata;
        end
      end
    end

    $display("[TB] counter saturation with CNT_W=2");
    resetDut();
    s_i.read = 1; s_i.address = 32'h40;
    s_c.resp = 1;
    grants = 0;
    for (int k = 0; k < 40 && grants < 5; k++) begin
      @(negedge clk);
      #1;
      if (s_c.read) grants++;
    end
    checkOutput("sat_grants_seen", grants, 5);
    checkOutput("sat_i_cnt", s_icnt, 2'd3);
    checkOutput("sat_d_cnt", s_dcnt, 2'd0);
    clearInputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
